// File: rtl/mult4u_sched_pkg.sv
// Shared definitions for the DMR multiplier scheduler.
// Holds the FSM state type and the datapath widths used by the
// scheduler top and its round-robin arbiter.
package mult4u_sched_pkg;

  localparam int OPW    = 4;
  localparam int PRODW  = 8;
  localparam int CNTW   = 8;
  // Wide enough for any retry budget from 0 to 7.
  localparam int RETRYW = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN1,
    RUN2,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - last served requester; the search starts at ptr+1
//   enable - when low, no grant is produced
//   grant  - one-hot grant (all zero when nothing is granted)
//   idx    - encoded index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int             cand;
  logic [IDW-1:0] cand_idx;
  logic           found;

  // Walk the requesters starting just after the last winner and take the
  // first active one, so the previous winner ends up with lowest priority.
  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(ptr) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (enable && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mult4u_dmr_sched.sv
// Time-shared scheduler for a single 4x4 unsigned multiplier core.
// Requests are picked round-robin, each product is computed twice with the
// operands swapped (A*B, then B*A), and the two results are compared.  A
// mismatch triggers a re-execution until the retry budget is spent, after
// which the first result is returned with rsp_err set.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   req_valid/ready    - per-requester handshake (ready only in IDLE)
//   req_a/req_b        - packed operands, requester i at [4i+3:4i]
//   rsp_valid/ready    - response handshake
//   rsp_id/prod/err    - served requester, product, untrusted flag
//   mismatch_cnt       - saturating count of all DMR mismatches
//   mult_a/mult_b      - operands to the external multiplier core
//   mult_p             - combinational product from the core
module mult4u_dmr_sched
  import mult4u_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_RETRY = 2,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PRODW-1:0]    rsp_prod,
  output logic                rsp_err,
  output logic [CNTW-1:0]     mismatch_cnt,
  output logic [OPW-1:0]      mult_a,
  output logic [OPW-1:0]      mult_b,
  input  logic [PRODW-1:0]    mult_p
);

  state_t            state;
  state_t            next_state;
  logic [OPW-1:0]    op_a;
  logic [OPW-1:0]    op_b;
  logic [IDW-1:0]    rr_ptr;
  logic [RETRYW-1:0] retry;
  logic [PRODW-1:0]  p1;
  logic              arb_en;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              accept;
  logic              runs_match;
  logic              can_retry;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the state register already sits in IDLE.
  assign arb_en = (state == IDLE) && rst_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (arb_en),
    .grant  (grant),
    .idx    (grant_idx)
  );

  assign req_ready  = grant;
  assign accept     = |grant;
  assign runs_match = (mult_p == p1);
  assign can_retry  = (retry < RETRYW'(MAX_RETRY));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a failed comparison loops back to RUN1 while retries
  // remain, otherwise the result (trusted or not) goes to RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN1;
      RUN1:    next_state = RUN2;
      RUN2:    if (!runs_match && can_retry) next_state = RUN1;
               else next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: the core operands stay at zero outside the run states so
  // the shared multiplier does not toggle while idle or waiting.
  always_comb begin
    mult_a    = '0;
    mult_b    = '0;
    rsp_valid = 1'b0;
    case (state)
      RUN1: begin
        mult_a = op_a;
        mult_b = op_b;
      end
      RUN2: begin
        mult_a = op_b;
        mult_b = op_a;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture at handshake, first-run product, result and
  // error registers, retry counter and the saturating mismatch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a         <= '0;
      op_b         <= '0;
      rr_ptr       <= IDW'(NREQ - 1);
      retry        <= '0;
      p1           <= '0;
      rsp_id       <= '0;
      rsp_prod     <= '0;
      rsp_err      <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a[OPW*grant_idx +: OPW];
        op_b   <= req_b[OPW*grant_idx +: OPW];
        rsp_id <= grant_idx;
        rr_ptr <= grant_idx;
        retry  <= '0;
      end
      if (state == RUN1) begin
        p1 <= mult_p;
      end
      if (state == RUN2) begin
        if (!runs_match) begin
          if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNTW'(1);
          if (can_retry) retry <= retry + RETRYW'(1);
        end
        if (runs_match || !can_retry) begin
          rsp_prod <= p1;
          rsp_err  <= !runs_match;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult4u_dmr_sched.sv
// Self-checking bench for mult4u_dmr_sched with a behavioural multiplier
// that can inject a stuck-at fault or a one-shot transient fault.
module tb_mult4u_dmr_sched;
  import mult4u_sched_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_RETRY = 2;
  localparam int IDW       = 2;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [3:0]      a;
    logic [3:0]      b;
    logic            stuck;
    logic [IDW-1:0]  exp_id;
    logic [7:0]      exp_prod;
    logic            exp_err;
    int              exp_lat;
    logic [7:0]      exp_mcnt;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     prod;
    logic           err;
    int             t_hs;
    int             lat;
    logic [7:0]     mcnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_prod;
  logic              rsp_err;
  logic [7:0]        mismatch_cnt;
  logic [3:0]        mult_a;
  logic [3:0]        mult_b;
  logic [7:0]        mult_p;
  logic              stuck_en = 1'b0;
  logic              transient_armed = 1'b0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vecs[10];

  mult4u_dmr_sched #(
    .NREQ      (NREQ),
    .MAX_RETRY (MAX_RETRY),
    .IDW       (IDW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_prod     (rsp_prod),
    .rsp_err      (rsp_err),
    .mismatch_cnt (mismatch_cnt),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_p       (mult_p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal multiplier plus optional faults: bit0 stuck-1 for 2*3 only, and a
  // one-shot flip of bit0 for 9*5 while armed.
  always_comb begin
    mult_p = {4'b0, mult_a} * {4'b0, mult_b};
    if (stuck_en && mult_a == 4'd2 && mult_b == 4'd3) mult_p[0] = 1'b1;
    if (transient_armed && mult_a == 4'd9 && mult_b == 4'd5) mult_p[0] = ~mult_p[0];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: got no event, want event within cycle bound", name);
  endtask

  task automatic driveLanes(input logic [3:0] a, input logic [3:0] b, input logic [IDW-1:0] id);
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = (i == int'(id)) ? a : ~a;
      req_b[4*i +: 4] = (i == int'(id)) ? b : ~b;
    end
  endtask

  // Pops the oldest expected response and compares it with the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      failNow("unexpected_response");
      return;
    end
    e = sb.pop_front();
    compare("rsp_id", 32'(rsp_id), 32'(e.id));
    compare("rsp_prod", 32'(rsp_prod), 32'(e.prod));
    compare("rsp_err", 32'(rsp_err), 32'(e.err));
    compare("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mcnt));
    if (e.lat >= 0) compare("latency", 32'(cyc - e.t_hs), 32'(e.lat));
  endtask

  // Presents one request, pushes its expectation at handshake, then waits
  // for the response and checks it.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   got;
    bit   disarm;
    driveLanes(v.a, v.b, v.exp_id);
    stuck_en  = v.stuck;
    req_valid = v.valid;
    #1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if ((req_valid & req_ready) != '0) begin
        got = 1;
        e = '{v.exp_id, v.exp_prod, v.exp_err, cyc, v.exp_lat, v.exp_mcnt};
        sb.push_back(e);
      end
      step();
    end
    req_valid = '0;
    if (!got) begin
      failNow("handshake_timeout");
      return;
    end
    got    = 0;
    disarm = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      if (rsp_valid) begin
        checkOutput();
        got = 1;
      end
      if (transient_armed && mult_a == 4'd9 && mult_b == 4'd5) disarm = 1;
      step();
      if (disarm) transient_armed = 1'b0;
    end
    if (!got) failNow("response_timeout");
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   t_hs;
    int   n_hs;
    int   last_hs;
    int   mc;
    bit   got;
    int   order[5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] exp_g;

    // Operand-packing vectors put the wanted operands only on the expected
    // winner's lane, so a wrong grant also shows up as a wrong product.
    vecs[0] = '{4'b0001, 4'd13, 4'd11, 1'b0, 2'd0, 8'd143, 1'b0, 3, 8'd0};
    vecs[1] = '{4'b0100, 4'd7,  4'd9,  1'b0, 2'd2, 8'd63,  1'b0, 3, 8'd0};
    vecs[2] = '{4'b1000, 4'd15, 4'd0,  1'b0, 2'd3, 8'd0,   1'b0, 3, 8'd0};
    vecs[3] = '{4'b0010, 4'd15, 4'd15, 1'b0, 2'd1, 8'd225, 1'b0, 3, 8'd0};
    vecs[4] = '{4'b0010, 4'd2,  4'd3,  1'b1, 2'd1, 8'd7,   1'b1, 7, 8'd3};
    vecs[5] = '{4'b0001, 4'd3,  4'd2,  1'b1, 2'd0, 8'd6,   1'b1, 7, 8'd6};
    vecs[6] = '{4'b0101, 4'd4,  4'd4,  1'b0, 2'd2, 8'd16,  1'b0, 3, 8'd6};
    vecs[7] = '{4'b0101, 4'd5,  4'd6,  1'b0, 2'd0, 8'd30,  1'b0, 3, 8'd6};
    vecs[8] = '{4'b1111, 4'd1,  4'd15, 1'b0, 2'd1, 8'd15,  1'b0, 3, 8'd6};
    vecs[9] = '{4'b1111, 4'd0,  4'd9,  1'b0, 2'd2, 8'd0,   1'b0, 3, 8'd6};

    // Reset values, with requests pending to show req_ready stays low.
    req_valid = 4'b1111;
    step();
    step();
    compare("reset_rsp_valid", 32'(rsp_valid), 0);
    compare("reset_rsp_id", 32'(rsp_id), 0);
    compare("reset_rsp_prod", 32'(rsp_prod), 0);
    compare("reset_rsp_err", 32'(rsp_err), 0);
    compare("reset_mismatch_cnt", 32'(mismatch_cnt), 0);
    compare("reset_mult_a", 32'(mult_a), 0);
    compare("reset_mult_b", 32'(mult_b), 0);
    compare("reset_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Keep the stuck fault active until the mismatch counter saturates.
    mc = 6;
    for (int n = 0; n < 84; n++) begin
      mc = (mc + 3 > 255) ? 255 : mc + 3;
      v = '{4'b0001, 4'd2, 4'd3, 1'b1, 2'd0, 8'd7, 1'b1, 7, 8'(mc)};
      applyStimulus(v);
    end
    stuck_en = 1'b0;
    compare("mismatch_cnt_saturated", 32'(mismatch_cnt), 255);

    // Reset while the second run is in flight.
    driveLanes(4'd6, 4'd7, 2'd1);
    req_valid = 4'b0010;
    #1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if ((req_valid & req_ready) != '0) got = 1;
      step();
    end
    if (!got) failNow("rst_test_handshake");
    req_valid = '0;
    step();
    compare("run2_mult_a_swapped", 32'(mult_a), 7);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    compare("midrst_rsp_valid", 32'(rsp_valid), 0);
    compare("midrst_rsp_id", 32'(rsp_id), 0);
    compare("midrst_rsp_prod", 32'(rsp_prod), 0);
    compare("midrst_rsp_err", 32'(rsp_err), 0);
    compare("midrst_mismatch_cnt", 32'(mismatch_cnt), 0);
    compare("midrst_mult_a", 32'(mult_a), 0);
    compare("midrst_mult_b", 32'(mult_b), 0);
    compare("midrst_req_ready", 32'(req_ready), 0);
    step();
    step();
    req_valid = '0;
    rst_n = 1'b1;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      step();
      compare("no_stale_rsp", 32'(rsp_valid), 0);
    end
    v = '{4'b1111, 4'd6, 4'd7, 1'b0, 2'd0, 8'd42, 1'b0, 3, 8'd0};
    applyStimulus(v);

    // One-shot fault on the first swapped run only.
    transient_armed = 1'b1;
    v = '{4'b0010, 4'd5, 4'd9, 1'b0, 2'd1, 8'd45, 1'b0, 5, 8'd1};
    applyStimulus(v);
    compare("transient_disarmed", 32'(transient_armed), 0);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    driveLanes(4'd9, 4'd9, 2'd3);
    req_valid = 4'b1000;
    #1;
    got = 0;
    t_hs = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if ((req_valid & req_ready) != '0) begin
        got = 1;
        t_hs = cyc;
        e = '{2'd3, 8'd81, 1'b0, cyc, -1, 8'd1};
        sb.push_back(e);
      end
      step();
    end
    if (!got) failNow("bp_handshake");
    req_a[3:0] = 4'd8;
    req_b[3:0] = 4'd8;
    req_valid = 4'b0001;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (rsp_valid) got = 1;
      else step();
    end
    if (!got) failNow("bp_response");
    compare("bp_latency", 32'(cyc - t_hs), 3);
    compare("bp_mult_a_idle", 32'(mult_a), 0);
    for (int k = 0; k < 10; k++) begin
      compare("bp_rsp_valid", 32'(rsp_valid), 1);
      compare("bp_rsp_id", 32'(rsp_id), 3);
      compare("bp_rsp_prod", 32'(rsp_prod), 81);
      compare("bp_req_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    checkOutput();
    step();
    compare("bp_next_grant", 32'(req_ready), 32'(4'b0001));
    v = '{4'b0001, 4'd8, 4'd8, 1'b0, 2'd0, 8'd64, 1'b0, 3, 8'd1};
    applyStimulus(v);

    // All requesters valid continuously: rotation order and 4-cycle cadence.
    doReset();
    driveLanes(4'd15, 4'd15, 2'd0);
    req_a = '1;
    req_b = '1;
    req_valid = 4'b1111;
    #1;
    n_hs = 0;
    last_hs = 0;
    for (int k = 0; k < 60 && n_hs < 5; k++) begin
      if (rsp_valid) checkOutput();
      if ((req_valid & req_ready) != '0) begin
        exp_g = NREQ'(1) << order[n_hs];
        compare("rr_grant", 32'(req_ready), 32'(exp_g));
        if (n_hs > 0) compare("rr_gap", 32'(cyc - last_hs), 4);
        e = '{IDW'(order[n_hs]), 8'd225, 1'b0, cyc, 3, 8'd0};
        sb.push_back(e);
        last_hs = cyc;
        n_hs++;
      end
      step();
    end
    req_valid = '0;
    if (n_hs < 5) failNow("rr_handshakes");
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      if (rsp_valid) checkOutput();
      step();
    end
    compare("scoreboard_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
